// File: rtl/tinker_pkg.sv
// tinker_pkg: shared FSM, requester and size types for the tinker memory arbiter
package tinker_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {REQ_IF, REQ_DM} req_id_t;
  localparam logic SIZE_4B = 1'b0;
  localparam logic SIZE_8B = 1'b1;
  function automatic logic oob(input logic [31:0] addr, input req_id_t id, input logic [32:0] limit);
    return ({1'b0, addr} + (id == REQ_DM ? 33'd8 : 33'd4)) > limit;
  endfunction
endpackage

// File: rtl/tinker_rr_pick.sv
// tinker_rr_pick: two-way round-robin grant with a registered last-grant pointer
module tinker_rr_pick
  import tinker_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_if,
  input  logic req_dm,
  output logic gnt_if,
  output logic gnt_dm
);
  req_id_t last;
  always_ff @(posedge clk)
    if (reset) last <= REQ_DM;
    else if (gnt_if || gnt_dm) last <= gnt_dm ? REQ_DM : REQ_IF;
  always_comb begin
    gnt_if = en && req_if && (!req_dm || last == REQ_DM);
    gnt_dm = en && req_dm && (!req_if || last == REQ_IF);
  end
endmodule

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: round-robin arbitration of fetch and data ports onto one memory
module tinker_mem_arbiter
  import tinker_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MEM_SIZE = 524288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  output logic        dm_rsp_valid,
  output logic [63:0] dm_rsp_data,
  output logic        dm_rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_size,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  localparam logic [32:0] LIMIT = 33'(MEM_SIZE);
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 2);
  state_t state, state_n;
  logic [1:0] cnt;
  req_id_t id, hs_id;
  logic err, hs, hs_err, gnt_if, gnt_dm;
  logic [31:0] hs_addr;
  tinker_rr_pick u_pick (
    .clk,
    .reset,
    .en(state == IDLE && !reset),
    .req_if(if_req_valid),
    .req_dm(dm_req_valid),
    .gnt_if,
    .gnt_dm
  );
  assign if_req_ready = gnt_if;
  assign dm_req_ready = gnt_dm;
  always_comb begin
    hs = gnt_if || gnt_dm;
    hs_id = gnt_dm ? REQ_DM : REQ_IF;
    hs_addr = gnt_dm ? dm_req_addr : if_req_addr;
    hs_err = oob(hs_addr, hs_id, LIMIT);
  end
  // With a one-cycle memory the read data is already valid in the cycle after ISSUE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !hs ? IDLE : hs_err ? RESP : ISSUE;
      ISSUE:   state_n = (mem_we || RD_LATENCY == 1) ? RESP : WAIT;
      WAIT:    state_n = cnt == WAIT_LAST ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      id <= REQ_IF;
      err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_size <= SIZE_4B;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data <= '0;
      if_rsp_err <= 1'b0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data <= '0;
      dm_rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == WAIT && state_n == WAIT) ? cnt + 2'd1 : 2'd0;
      mem_en <= state_n == ISSUE;
      if (hs) begin
        id <= hs_id;
        err <= hs_err;
        mem_we <= gnt_dm && dm_req_we;
        mem_size <= gnt_dm ? SIZE_8B : SIZE_4B;
        mem_addr <= hs_addr;
        mem_wdata <= gnt_dm ? dm_req_wdata : '0;
      end
      if_rsp_valid <= state == RESP && id == REQ_IF;
      dm_rsp_valid <= state == RESP && id == REQ_DM;
      if (state == RESP && id == REQ_IF) begin
        if_rsp_data <= err ? '0 : mem_rdata[31:0];
        if_rsp_err <= err;
      end
      if (state == RESP && id == REQ_DM) begin
        dm_rsp_data <= (err || mem_we) ? '0 : mem_rdata;
        dm_rsp_err <= err;
      end
    end
endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: directed plus random stimulus against a transaction-level model
module tb_tinker_mem_arbiter;
  localparam int MEM_SIZE = 524288;
  typedef struct {int due; logic [63:0] data; logic err; logic dm;} rsp_t;
  typedef struct {int due; logic [31:0] addr; logic we; logic dm; logic [63:0] wdata;} mem_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [31:0] if_req_addr  [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rsp_data  [2];
  logic        if_rsp_err   [2];
  logic        dm_req_valid [2];
  logic        dm_req_ready [2];
  logic        dm_req_we    [2];
  logic [31:0] dm_req_addr  [2];
  logic [63:0] dm_req_wdata [2];
  logic        dm_rsp_valid [2];
  logic [63:0] dm_rsp_data  [2];
  logic        dm_rsp_err   [2];
  logic        mem_en       [2];
  logic        mem_we       [2];
  logic        mem_size     [2];
  logic [31:0] mem_addr     [2];
  logic [63:0] mem_wdata    [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] pat(input logic [31:0] a);
    return a == 32'h2000 ? 64'h0000_0000_DEAD_BEEF : {a ^ 32'h5A5A_5A5A, ~a};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = g == 0 ? 1 : 4;
    logic [63:0] mem_rdata;
    logic pv [4] = '{default: 1'b0};
    logic [63:0] pd [4];
    logic [63:0] garb = '0;
    rsp_t rq[$];
    mem_t mq[$];
    rsp_t rr;
    mem_t mm;
    int free_at = 0;
    int lat;
    logic last_dm = 1'b1;
    logic em, rv_if, rv_dm, g_if, g_dm, e, w;
    logic [31:0] a;
    tinker_mem_arbiter #(.RD_LATENCY(LAT), .MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid[g]), .if_req_ready(if_req_ready[g]), .if_req_addr(if_req_addr[g]),
      .if_rsp_valid(if_rsp_valid[g]), .if_rsp_data(if_rsp_data[g]), .if_rsp_err(if_rsp_err[g]),
      .dm_req_valid(dm_req_valid[g]), .dm_req_ready(dm_req_ready[g]), .dm_req_we(dm_req_we[g]),
      .dm_req_addr(dm_req_addr[g]), .dm_req_wdata(dm_req_wdata[g]),
      .dm_rsp_valid(dm_rsp_valid[g]), .dm_rsp_data(dm_rsp_data[g]), .dm_rsp_err(dm_rsp_err[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_size(mem_size[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata)
    );
    // Memory: read data valid only in the LAT-th cycle after mem_en, noise otherwise.
    always @(posedge clk) begin
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= pat(mem_addr[g]);
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      garb <= {$urandom, $urandom};
    end
    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : garb;
    // Transaction model: a handshake in cycle c lands on edge c+1; the block is busy until its response.
    always @(negedge clk) begin
      if (reset) begin
        rq.delete();
        mq.delete();
        free_at = 0;
        last_dm = 1'b1;
      end else begin
        chk("two_ready", 64'(if_req_ready[g] && dm_req_ready[g]), 64'h0);
        em = mq.size() > 0 && mq[0].due == cyc;
        chk("mem_en", 64'(mem_en[g]), 64'(em));
        if (em) begin
          mm = mq.pop_front();
          chk("mem_addr", 64'(mem_addr[g]), 64'(mm.addr));
          chk("mem_we", 64'(mem_we[g]), 64'(mm.we));
          chk("mem_size", 64'(mem_size[g]), 64'(mm.dm));
          if (mm.we) chk("mem_wdata", mem_wdata[g], mm.wdata);
        end
        rv_if = 1'b0;
        rv_dm = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          rr = rq.pop_front();
          rv_if = !rr.dm;
          rv_dm = rr.dm;
        end
        chk("if_rsp_valid", 64'(if_rsp_valid[g]), 64'(rv_if));
        chk("dm_rsp_valid", 64'(dm_rsp_valid[g]), 64'(rv_dm));
        if (rv_if) begin
          chk("if_rsp_data", 64'(if_rsp_data[g]), rr.data);
          chk("if_rsp_err", 64'(if_rsp_err[g]), 64'(rr.err));
        end
        if (rv_dm) begin
          chk("dm_rsp_data", dm_rsp_data[g], rr.data);
          chk("dm_rsp_err", 64'(dm_rsp_err[g]), 64'(rr.err));
        end
        g_if = cyc >= free_at && if_req_valid[g] && (!dm_req_valid[g] || last_dm);
        g_dm = cyc >= free_at && dm_req_valid[g] && (!if_req_valid[g] || !last_dm);
        chk("if_req_ready", 64'(if_req_ready[g]), 64'(g_if));
        chk("dm_req_ready", 64'(dm_req_ready[g]), 64'(g_dm));
        if (g_if || g_dm) begin
          a = g_dm ? dm_req_addr[g] : if_req_addr[g];
          w = g_dm && dm_req_we[g];
          e = ({32'h0, a} + (g_dm ? 64'd8 : 64'd4)) > 64'(MEM_SIZE);
          lat = e ? 1 : w ? 2 : LAT + 1;
          if (!e) mq.push_back('{cyc + 1, a, w, g_dm, dm_req_wdata[g]});
          rq.push_back('{cyc + 1 + lat, (e || w) ? 64'h0 : g_dm ? pat(a) : (pat(a) & 64'hFFFF_FFFF), e, g_dm});
          free_at = cyc + 1 + lat;
          last_dm = g_dm;
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input int d, input logic dm, input logic we, input logic [31:0] a, input logic [63:0] wd);
    logic got;
    got = 1'b0;
    if (dm) begin
      dm_req_valid[d] = 1'b1;
      dm_req_we[d] = we;
      dm_req_addr[d] = a;
      dm_req_wdata[d] = wd;
    end else begin
      if_req_valid[d] = 1'b1;
      if_req_addr[d] = a;
    end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = dm ? dm_req_ready[d] : if_req_ready[d];
    end
    chk("req_handshake", 64'(got), 64'h1);
    step(1);
    if_req_valid[d] = 1'b0;
    dm_req_valid[d] = 1'b0;
  endtask
  task automatic chk_zero(input int d);
    chk("rst_if_ready", 64'(if_req_ready[d]), 64'h0);
    chk("rst_dm_ready", 64'(dm_req_ready[d]), 64'h0);
    chk("rst_if_rsp_valid", 64'(if_rsp_valid[d]), 64'h0);
    chk("rst_if_rsp_data", 64'(if_rsp_data[d]), 64'h0);
    chk("rst_if_rsp_err", 64'(if_rsp_err[d]), 64'h0);
    chk("rst_dm_rsp_valid", 64'(dm_rsp_valid[d]), 64'h0);
    chk("rst_dm_rsp_data", dm_rsp_data[d], 64'h0);
    chk("rst_dm_rsp_err", 64'(dm_rsp_err[d]), 64'h0);
    chk("rst_mem_en", 64'(mem_en[d]), 64'h0);
    chk("rst_mem_we", 64'(mem_we[d]), 64'h0);
    chk("rst_mem_size", 64'(mem_size[d]), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr[d]), 64'h0);
    chk("rst_mem_wdata", mem_wdata[d], 64'h0);
  endtask
  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, MEM_SIZE / 8 - 1) * 8);
      1: return 32'(MEM_SIZE - int'($urandom_range(0, 12)));
      2: return 32'hFFFF_FFF0 + $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic got, exp_dm;
    for (int d = 0; d < 2; d++) begin
      if_req_valid[d] = 1'b0;
      if_req_addr[d] = '0;
      dm_req_valid[d] = 1'b0;
      dm_req_we[d] = 1'b0;
      dm_req_addr[d] = '0;
      dm_req_wdata[d] = '0;
    end
    step(3);
    chk_zero(0);
    chk_zero(1);
    reset = 1'b0;
    step(2);
    req(0, 1'b0, 1'b0, 32'h2000, 64'h0);
    step(4);
    if_req_addr[0] = 32'h104;
    dm_req_addr[0] = 32'h100;
    dm_req_we[0] = 1'b0;
    if_req_valid[0] = 1'b1;
    dm_req_valid[0] = 1'b1;
    exp_dm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = if_req_ready[0] || dm_req_ready[0];
      end
      chk("rr_handshake", 64'(got), 64'h1);
      chk("rr_order", 64'(dm_req_ready[0]), 64'(exp_dm));
      exp_dm = !exp_dm;
      step(1);
    end
    if_req_valid[0] = 1'b0;
    dm_req_valid[0] = 1'b0;
    step(4);
    req(0, 1'b1, 1'b1, 32'h10000, 64'h0123_4567_89AB_CDEF);
    step(4);
    req(0, 1'b1, 1'b0, 32'h7FFF9, 64'h0);
    step(3);
    req(0, 1'b1, 1'b0, 32'h7FFF8, 64'h0);
    step(4);
    req(0, 1'b0, 1'b0, 32'h7FFFC, 64'h0);
    step(4);
    req(0, 1'b0, 1'b0, 32'h7FFFD, 64'h0);
    step(3);
    req(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 64'h0);
    step(3);
    req(1, 1'b1, 1'b0, 32'h0000_0040, 64'h0);
    step(8);
    req(1, 1'b0, 1'b0, 32'h0000_2000, 64'h0);
    step(8);
    req(1, 1'b1, 1'b0, 32'h0000_0080, 64'h0);
    step(1);
    reset = 1'b1;
    step(1);
    chk_zero(1);
    reset = 1'b0;
    step(8);
    req(1, 1'b1, 1'b0, 32'h0000_0088, 64'h0);
    step(8);
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if_req_valid[d] = $urandom_range(0, 2) != 0;
        if_req_addr[d] = raddr();
        dm_req_valid[d] = $urandom_range(0, 2) != 0;
        dm_req_we[d] = 1'($urandom_range(0, 1));
        dm_req_addr[d] = raddr();
        dm_req_wdata[d] = {$urandom, $urandom};
      end
      step(1);
    end
    for (int d = 0; d < 2; d++) begin
      if_req_valid[d] = 1'b0;
      dm_req_valid[d] = 1'b0;
    end
    step(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
